// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: port FSM state type and width helpers.
// id_w/dest_w are also used by the arbiter. They never return 0, so a
// single-entry configuration still gets a 1-bit field.
package xbar_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } xbar_port_state_t;

    function automatic int unsigned id_w(input int unsigned s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

    function automatic int unsigned dest_w(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/xbar_skid_buffer.sv
// Two-entry FIFO skid buffer.
//  clk, rst                  clock, synchronous active-high reset
//  in_data/in_valid/in_ready  upstream handshake (in_ready depends only on registered fill level)
//  out_data/out_valid/out_ready downstream handshake; out_data is read straight from storage
module xbar_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // Handshake flags come from the registered count only.
    always_comb begin
        in_ready  = (count != 2'd2);
        out_valid = (count != 2'd0);
        out_data  = mem[rd_ptr];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Storage, pointers and fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/xbar_m_port_mux.sv
// Per-master-port output stage: locks onto the granted slave stream for one
// packet, muxes it into a 2-entry skid buffer and reports packet completion.
//  clk, rst                       clock, synchronous active-high reset
//  grant_valid, grant_id          grant from this port's arbiter (taken in IDLE only)
//  grant_done                     1-cycle pulse after the locked packet's last beat is accepted
//  s_data_i/s_valid_i/s_last_i    slave streams, valid already qualified by destination
//  s_ready_o                      one-hot (or zero) ready back to the slaves
//  m_data_o/m_id_o/m_last_o       master beat, id = source slave index
//  m_valid_o/m_ready_i            master handshake
module xbar_m_port_mux
    import xbar_pkg::*;
#(
    parameter int unsigned S_DATA_COUNT = 2,
    parameter int unsigned M_DATA_COUNT = 3,
    parameter int unsigned T_DATA_WIDTH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       grant_valid,
    input  logic [id_w(S_DATA_COUNT)-1:0]              grant_id,
    output logic                                       grant_done,
    input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]  s_data_i,
    input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
    input  logic [S_DATA_COUNT-1:0]                    s_last_i,
    output logic [S_DATA_COUNT-1:0]                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                    m_data_o,
    output logic [id_w(S_DATA_COUNT)-1:0]              m_id_o,
    output logic                                       m_last_o,
    output logic                                       m_valid_o,
    input  logic                                       m_ready_i
);

    localparam int unsigned T_ID___WIDTH = id_w(S_DATA_COUNT);
    localparam int unsigned T_DEST_WIDTH = dest_w(M_DATA_COUNT);
    localparam int unsigned BUF_WIDTH    = T_DATA_WIDTH + 1 + T_ID___WIDTH;

    // Reject configurations the arbiter/decoder could not address.
    if (S_DATA_COUNT < 1 || T_DEST_WIDTH < 1) begin : g_bad_params
        $error("xbar_m_port_mux: invalid parameters");
    end

    xbar_port_state_t          state;
    xbar_port_state_t          state_nxt;
    logic [T_ID___WIDTH-1:0]   sel;
    logic [T_ID___WIDTH-1:0]   sel_nxt;
    logic                      grant_done_nxt;
    logic                      buf_in_ready;
    logic                      buf_in_valid;
    logic                      accept;
    logic                      sel_last;
    logic [BUF_WIDTH-1:0]      buf_in;
    logic [BUF_WIDTH-1:0]      buf_out;

    // Input mux and per-slave ready; ready uses the registered buffer level only.
    always_comb begin
        s_ready_o    = '0;
        sel_last     = s_last_i[sel];
        buf_in_valid = (state == LOCK) && s_valid_i[sel];
        accept       = buf_in_valid && buf_in_ready;
        buf_in       = {s_data_i[sel], sel_last, sel};
        if (state == LOCK && buf_in_ready) begin
            s_ready_o[sel] = 1'b1;
        end
    end

    // Packet lock FSM: out-of-range grants are ignored, grants are ignored while locked.
    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        grant_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid && (32'(grant_id) < S_DATA_COUNT)) begin
                    state_nxt = LOCK;
                    sel_nxt   = grant_id;
                end
            end
            LOCK: begin
                if (accept && sel_last) begin
                    state_nxt      = IDLE;
                    grant_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, selection and done-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            grant_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            grant_done <= grant_done_nxt;
        end
    end

    xbar_skid_buffer #(
        .WIDTH (BUF_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (buf_in),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .out_data  (buf_out),
        .out_valid (m_valid_o),
        .out_ready (m_ready_i)
    );

    assign {m_data_o, m_last_o, m_id_o} = buf_out;

endmodule

// File: tb/tb_xbar_m_port_mux.sv
// Self-checking bench for xbar_m_port_mux with 3 slaves so an out-of-range
// grant id is representable. Slaves are modelled as beat queues that hold
// TVALID until their beat is taken; a packet-level queue model predicts outputs.
module tb_xbar_m_port_mux;

    localparam int S = 3;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic [1:0]   id;
    } out_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                grant_valid;
    logic [1:0]          grant_id;
    logic                grant_done;
    logic [S-1:0][W-1:0] s_data;
    logic [S-1:0]        s_valid;
    logic [S-1:0]        s_last;
    logic [S-1:0]        s_ready;
    logic [W-1:0]        m_data;
    logic [1:0]          m_id;
    logic                m_last;
    logic                m_valid;
    logic                m_ready;

    xbar_m_port_mux #(
        .S_DATA_COUNT (S),
        .M_DATA_COUNT (3),
        .T_DATA_WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_done  (grant_done),
        .s_data_i    (s_data),
        .s_valid_i   (s_valid),
        .s_last_i    (s_last),
        .s_ready_o   (s_ready),
        .m_data_o    (m_data),
        .m_id_o      (m_id),
        .m_last_o    (m_last),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;

    beat_t src_q [S][$];
    out_t  out_log [$];

    // Reference model: lock flag, locked slave, buffered beats, done pulse.
    bit    mdl_locked;
    int    mdl_sel;
    out_t  mdl_q [$];
    bit    mdl_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_pkt(input int s, input int len, input logic [W-1:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + W'(k);
            b.last = (k == len - 1);
            src_q[s].push_back(b);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_step();
        bit   pop;
        bit   rdy;
        bit   acc;
        out_t o;
        if (rst) begin
            mdl_locked = 0;
            mdl_sel    = 0;
            mdl_q.delete();
            mdl_done   = 0;
            return;
        end
        pop = (mdl_q.size() > 0) && m_ready;
        rdy = mdl_locked && (mdl_q.size() < 2);
        acc = rdy && (src_q[mdl_sel].size() > 0);
        mdl_done = 0;
        if (pop) void'(mdl_q.pop_front());
        if (acc) begin
            o.data = src_q[mdl_sel][0].data;
            o.last = src_q[mdl_sel][0].last;
            o.id   = 2'(mdl_sel);
            mdl_q.push_back(o);
            void'(src_q[mdl_sel].pop_front());
        end
        if (!mdl_locked) begin
            if (grant_valid && int'(grant_id) < S) begin
                mdl_locked = 1;
                mdl_sel    = int'(grant_id);
            end
        end else if (acc && o.last) begin
            mdl_locked = 0;
            mdl_done   = 1;
        end
    endtask

    task automatic compare();
        logic [S-1:0] exp_rdy;
        exp_rdy = '0;
        if (mdl_locked && mdl_q.size() < 2) exp_rdy[mdl_sel] = 1'b1;
        check("s_ready", 32'(s_ready), 32'(exp_rdy));
        check("m_valid", 32'(m_valid), 32'(mdl_q.size() > 0));
        check("grant_done", 32'(grant_done), 32'(mdl_done));
        if (mdl_q.size() > 0) begin
            check("m_data", 32'(m_data), 32'(mdl_q[0].data));
            check("m_id",   32'(m_id),   32'(mdl_q[0].id));
            check("m_last", 32'(m_last), 32'(mdl_q[0].last));
        end
    endtask

    // One clock: drive slaves from their queues, log master handshakes, check.
    task automatic step();
        out_t o;
        for (int i = 0; i < S; i++) begin
            s_valid[i] = (src_q[i].size() > 0);
            s_data[i]  = s_valid[i] ? src_q[i][0].data : W'($urandom);
            s_last[i]  = s_valid[i] ? src_q[i][0].last : 1'($urandom);
        end
        #1;
        if (m_valid && m_ready && !rst) begin
            o.data = m_data;
            o.last = m_last;
            o.id   = m_id;
            out_log.push_back(o);
        end
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic check_log(input string tag, input int off, input int id,
                             input logic [W-1:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            if (off + k >= out_log.size()) begin
                check({tag, "_missing"}, 32'(out_log.size()), 32'(off + len));
                return;
            end
            check({tag, "_data"}, 32'(out_log[off + k].data), 32'(base + W'(k)));
            check({tag, "_id"},   32'(out_log[off + k].id),   32'(id));
            check({tag, "_last"}, 32'(out_log[off + k].last), 32'(k == len - 1));
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        grant_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < S; i++) src_q[i].delete();
        out_log.delete();
    endtask

    initial begin
        rst         = 1'b1;
        grant_valid = 1'b0;
        grant_id    = '0;
        m_ready     = 1'b0;
        s_data      = '0;
        s_valid     = '0;
        s_last      = '0;
        @(negedge clk);

        // Reset state.
        do_reset();
        check("rst_m_data", 32'(m_data), 32'h0);
        check("rst_m_id",   32'(m_id),   32'h0);
        check("rst_m_last", 32'(m_last), 32'h0);

        // Basic 3-beat packet from slave 1.
        m_ready = 1'b1;
        add_pkt(1, 3, 8'hA1);
        grant_valid = 1'b1; grant_id = 2'd1;
        step();
        grant_valid = 1'b0;
        repeat (6) step();
        check("t1_count", 32'(out_log.size()), 32'd3);
        check_log("t1", 0, 1, 8'hA1, 3);
        check("t1_ready_after", 32'(s_ready), 32'h0);

        // Backpressure: 4-beat packet with master stalled.
        do_reset();
        m_ready = 1'b0;
        add_pkt(0, 4, 8'h10);
        grant_valid = 1'b1; grant_id = 2'd0;
        step();
        grant_valid = 1'b0;
        repeat (6) step();
        check("bp_ready_low", 32'(s_ready), 32'h0);
        check("bp_hold_data", 32'(m_data), 32'h10);
        check("bp_pending",   32'(src_q[0].size()), 32'd2);
        m_ready = 1'b1;
        repeat (8) step();
        check("bp_count", 32'(out_log.size()), 32'd4);
        check_log("bp", 0, 0, 8'h10, 4);

        // Locking: mid-packet grant for slave 1 must wait for slave 0's last beat.
        do_reset();
        add_pkt(0, 3, 8'h20);
        add_pkt(1, 2, 8'h30);
        grant_valid = 1'b1; grant_id = 2'd0;
        step();
        grant_id = 2'd1;
        repeat (8) step();
        grant_valid = 1'b0;
        repeat (3) step();
        check("lk_count", 32'(out_log.size()), 32'd5);
        check_log("lk0", 0, 0, 8'h20, 3);
        check_log("lk1", 3, 1, 8'h30, 2);

        // Back-to-back single-beat packets.
        do_reset();
        add_pkt(0, 1, 8'h40);
        add_pkt(1, 1, 8'h50);
        grant_valid = 1'b1; grant_id = 2'd0;
        step();
        grant_id = 2'd1;
        step();
        step();
        grant_valid = 1'b0;
        repeat (4) step();
        check("b2b_count", 32'(out_log.size()), 32'd2);
        check_log("b2b0", 0, 0, 8'h40, 1);
        check_log("b2b1", 1, 1, 8'h50, 1);

        // Out-of-range grant is ignored.
        do_reset();
        add_pkt(0, 1, 8'h60);
        add_pkt(2, 1, 8'h61);
        grant_valid = 1'b1; grant_id = 2'd3;
        repeat (4) step();
        grant_valid = 1'b0;
        check("bad_ready", 32'(s_ready), 32'h0);
        check("bad_valid", 32'(m_valid), 32'h0);

        // Reset with two beats buffered, then a fresh grant.
        do_reset();
        m_ready = 1'b0;
        add_pkt(1, 4, 8'h70);
        grant_valid = 1'b1; grant_id = 2'd1;
        step();
        grant_valid = 1'b0;
        repeat (3) step();
        check("mid_full", 32'(m_valid), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < S; i++) src_q[i].delete();
        out_log.delete();
        check("mid_valid", 32'(m_valid), 32'h0);
        check("mid_ready", 32'(s_ready), 32'h0);
        check("mid_done",  32'(grant_done), 32'h0);
        m_ready = 1'b1;
        add_pkt(2, 2, 8'h80);
        grant_valid = 1'b1; grant_id = 2'd2;
        step();
        grant_valid = 1'b0;
        repeat (5) step();
        check("mid_count", 32'(out_log.size()), 32'd2);
        check_log("mid", 0, 2, 8'h80, 2);

        // Randomized traffic, grants, backpressure and occasional reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            m_ready     = ($urandom_range(0, 3) != 0);
            grant_valid = 1'($urandom_range(0, 1));
            grant_id    = 2'($urandom_range(0, 3));
            for (int i = 0; i < S; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 2) == 0)
                    add_pkt(i, $urandom_range(1, 4), W'($urandom));
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
            if (rst) begin
                for (int i = 0; i < S; i++) src_q[i].delete();
            end
            rst = 1'b0;
            out_log.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
